// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between the board-side controls and cpu_run_ctrl.
// master = board/bench side, slave = the sequencer.
interface cpu_run_ctrl_if #(
  parameter int unsigned ADDR_W = 32'd6
);
  logic              run_i;
  logic              slow_i;
  logic              step_i;
  logic              clr_i;
  logic              bp_en_i;
  logic [ADDR_W-1:0] bp_addr_i;
  logic [ADDR_W-1:0] pc_i;
  logic              cpu_en_o;
  logic [1:0]        state_o;
  logic              halted_o;
  logic [31:0]       retired_o;

  modport master (
    output run_i, slow_i, step_i, clr_i, bp_en_i, bp_addr_i, pc_i,
    input  cpu_en_o, state_o, halted_o, retired_o
  );

  modport slave (
    input  run_i, slow_i, step_i, clr_i, bp_en_i, bp_addr_i, pc_i,
    output cpu_en_o, state_o, halted_o, retired_o
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint sequencer producing a one-cycle CPU clock enable.
// Breakpoint halting is built only when CPU_RUN_CTRL_BREAKPOINT_EN is defined.
module cpu_run_ctrl #(
  parameter int unsigned DIV_FAST = 32'd25,
  parameter int unsigned DIV_SLOW = 32'd27,
  parameter logic [19:0] DB_LEN   = 20'd1000000,
  parameter int unsigned ADDR_W   = 32'd6
) (
  input  logic          clk,
  input  logic          rstn,
  cpu_run_ctrl_if.slave bus
);

  localparam int unsigned      DB_W      = $clog2(DB_LEN);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DB_LEN - 20'd1);
  localparam logic [31:0]      MASK_FAST = (32'd1 << DIV_FAST) - 32'd1;
  localparam logic [31:0]      MASK_SLOW = (32'd1 << DIV_SLOW) - 32'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10,
    ST_HALT = 2'b11
  } state_t;

  logic [31:0]     presc_r;
  logic            sync1_r, sync2_r, sync3_r;
  logic [DB_W-1:0] db_cnt_r;
  logic            db_level_r, db_level_d_r;
  state_t          state_r, state_nxt_s;
  logic [31:0]     retired_r;

  logic [31:0]     mask_s;
  logic            tick_s;
  logic            db_change_s;
  logic            step_pulse_s;
  logic            bp_hit_s;
  logic            cpu_en_s;

  assign mask_s       = bus.slow_i ? MASK_SLOW : MASK_FAST;
  assign tick_s       = ((presc_r & mask_s) == mask_s);
  assign db_change_s  = sync2_r ^ sync3_r;
  assign step_pulse_s = db_level_r & ~db_level_d_r;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  logic [ADDR_W-1:0] pc_s, bp_addr_s;
  assign pc_s         = bus.pc_i;
  assign bp_addr_s    = bus.bp_addr_i;
  assign bp_hit_s     = bus.bp_en_i & (pc_s == bp_addr_s);
  assign bus.halted_o = (state_r == ST_HALT);
`else
  logic [ADDR_W:0] unused_bp_s;
  assign unused_bp_s  = {bus.bp_en_i, bus.pc_i ^ bus.bp_addr_i};
  assign bp_hit_s     = 1'b0;
  assign bus.halted_o = 1'b0;
`endif

  // Free-running prescaler; the slow/fast select only changes which bits are tested.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_r <= 32'd0;
    end else begin
      presc_r <= presc_r + 32'd1;
    end
  end

  // Step button synchronizer, debounce counter and edge detector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      sync3_r      <= 1'b0;
      db_cnt_r     <= '0;
      db_level_r   <= 1'b0;
      db_level_d_r <= 1'b0;
    end else begin
      sync1_r      <= bus.step_i;
      sync2_r      <= sync1_r;
      sync3_r      <= sync2_r;
      db_level_d_r <= db_level_r;
      if (db_change_s) begin
        db_cnt_r <= '0;
      end else if (db_cnt_r == DB_LAST) begin
        db_level_r <= sync3_r;
      end else begin
        db_cnt_r <= db_cnt_r + DB_W'(1'b1);
      end
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and enable decode; clr_i overrides every state.
  always_comb begin
    state_nxt_s = state_r;
    cpu_en_s    = 1'b0;
    if (bus.clr_i) begin
      state_nxt_s = ST_IDLE;
      cpu_en_s    = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.run_i) begin
            state_nxt_s = ST_RUN;
          end else if (step_pulse_s) begin
            state_nxt_s = ST_STEP;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          // A breakpoint hit swallows the tick so the instruction at bp_addr never retires.
          if (tick_s && bp_hit_s) begin
            cpu_en_s    = 1'b0;
            state_nxt_s = ST_HALT;
          end else if (!bus.run_i) begin
            cpu_en_s    = tick_s;
            state_nxt_s = ST_IDLE;
          end else begin
            cpu_en_s    = tick_s;
            state_nxt_s = ST_RUN;
          end
        end
        ST_STEP: begin
          cpu_en_s    = 1'b1;
          state_nxt_s = ST_IDLE;
        end
        ST_HALT: begin
          if (step_pulse_s) begin
            state_nxt_s = ST_STEP;
          end else begin
            state_nxt_s = ST_HALT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cpu_en_s    = 1'b0;
        end
      endcase
    end
  end

  // Saturating retire counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retired_r <= 32'd0;
    end else if (bus.clr_i) begin
      retired_r <= 32'd0;
    end else if (cpu_en_s && (retired_r != 32'hFFFF_FFFF)) begin
      retired_r <= retired_r + 32'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  assign bus.cpu_en_o  = cpu_en_s;
  assign bus.state_o   = state_r;
  assign bus.retired_o = retired_r;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized self-checking bench for cpu_run_ctrl (DIV_FAST=2, DIV_SLOW=3, DB_LEN=4).
// Expected enables come from a tick-period model and a retire scoreboard.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  longint unsigned cyc;
  logic [31:0] ret_model = 32'd0;

  cpu_run_ctrl_if #(.ADDR_W(32'd6)) bus ();

  cpu_run_ctrl #(
    .DIV_FAST(32'd2), .DIV_SLOW(32'd3), .DB_LEN(20'd4), .ADDR_W(32'd6)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  always #5 clk = ~clk;

  // Clock cycles elapsed since reset release; the tick rule is defined on this count.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  function automatic bit model_tick(longint unsigned c, bit slow);
    longint unsigned period;
    period = slow ? 64'd8 : 64'd4;
    return (c % period) == (period - 64'd1);
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.run_i = 1'b0; bus.slow_i = 1'b0; bus.step_i = 1'b0; bus.clr_i = 1'b0;
    bus.bp_en_i = 1'b0; bus.bp_addr_i = 6'd0; bus.pc_i = 6'd0;
    rstn = 1'b0;
    repeat (3) next_cyc();
    #1;
    n_cmp++; if (bus.state_o !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", bus.state_o); end
    n_cmp++; if (bus.cpu_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", bus.cpu_en_o); end
    n_cmp++; if (bus.halted_o !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", bus.halted_o); end
    n_cmp++; if (bus.retired_o !== 32'd0) begin n_fail++; $display("FAIL reset_retired: got %h want 0", bus.retired_o); end
    @(negedge clk);
    rstn = 1'b1;
    ret_model = 32'd0;
    next_cyc();
  endtask

  task automatic run_burst(int len, bit slow0, bit toggle, bit check_count);
    bit slow, exp_en;
    int pulses;
    slow = slow0; pulses = 0;
    bus.slow_i = slow; bus.run_i = 1'b1;
    next_cyc();
    for (int i = 0; i < len; i++) begin
      if (toggle && ($urandom_range(0, 3) == 0)) slow = ~slow;
      bus.slow_i = slow;
      #1;
      exp_en = model_tick(cyc, slow);
      n_cmp++; if (bus.cpu_en_o !== exp_en) begin n_fail++; $display("FAIL run_en cyc=%0d slow=%b: got %b want %b", cyc, slow, bus.cpu_en_o, exp_en); end
      n_cmp++; if (bus.state_o !== 2'b01) begin n_fail++; $display("FAIL run_state: got %b want 01", bus.state_o); end
      if (exp_en) begin ret_model++; pulses++; end
      next_cyc();
    end
    if (check_count) begin
      n_cmp++; if (pulses != (slow0 ? 4 : 8)) begin n_fail++; $display("FAIL run_pulses: got %0d want %0d", pulses, slow0 ? 4 : 8); end
    end
    bus.run_i = 1'b0;
    #1;
    exp_en = model_tick(cyc, slow);
    n_cmp++; if (bus.cpu_en_o !== exp_en) begin n_fail++; $display("FAIL run_exit_en: got %b want %b", bus.cpu_en_o, exp_en); end
    if (exp_en) ret_model++;
    next_cyc(); #1;
    n_cmp++; if (bus.state_o !== 2'b00) begin n_fail++; $display("FAIL run_exit_state: got %b want 00", bus.state_o); end
    n_cmp++; if (bus.retired_o !== ret_model) begin n_fail++; $display("FAIL run_retired: got %0d want %0d", bus.retired_o, ret_model); end
  endtask

  task automatic test_run();
    run_burst(32, 1'b0, 1'b0, 1'b1);
    run_burst(32, 1'b1, 1'b0, 1'b1);
    for (int it = 0; it < 6; it++) begin
      repeat ($urandom_range(0, 5)) begin
        #1;
        n_cmp++; if (bus.cpu_en_o !== 1'b0) begin n_fail++; $display("FAIL idle_en: got %b want 0", bus.cpu_en_o); end
        next_cyc();
      end
      run_burst($urandom_range(1, 24), 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    end
  endtask

  // Presses step (already debounced-clean) and expects exactly one enable from STEP.
  task automatic press_step(string tag);
    int found;
    found = 0;
    bus.step_i = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      next_cyc(); #1;
      if (bus.cpu_en_o === 1'b1) begin
        found++;
        n_cmp++; if (bus.state_o !== 2'b10) begin n_fail++; $display("FAIL %s_step_state: got %b want 10", tag, bus.state_o); end
      end
    end
    n_cmp++; if (found != 1) begin n_fail++; $display("FAIL %s_step_pulses: got %0d want 1", tag, found); end
    ret_model++;
    n_cmp++; if (bus.state_o !== 2'b00) begin n_fail++; $display("FAIL %s_step_end_state: got %b want 00", tag, bus.state_o); end
    n_cmp++; if (bus.retired_o !== ret_model) begin n_fail++; $display("FAIL %s_step_retired: got %0d want %0d", tag, bus.retired_o, ret_model); end
    bus.step_i = 1'b0;
    repeat (12) begin
      next_cyc(); #1;
      n_cmp++; if (bus.cpu_en_o !== 1'b0) begin n_fail++; $display("FAIL %s_release_en: got %b want 0", tag, bus.cpu_en_o); end
    end
  endtask

  task automatic test_step();
    int found, lat;
    found = 0; lat = 0;
    bus.run_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.step_i = 1'b1;
      repeat ($urandom_range(1, 3)) begin
        next_cyc(); #1;
        n_cmp++; if (bus.cpu_en_o !== 1'b0 || bus.state_o !== 2'b00) begin n_fail++; $display("FAIL bounce: en=%b state=%b want 0/00", bus.cpu_en_o, bus.state_o); end
      end
      bus.step_i = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        next_cyc(); #1;
        n_cmp++; if (bus.cpu_en_o !== 1'b0 || bus.state_o !== 2'b00) begin n_fail++; $display("FAIL bounce: en=%b state=%b want 0/00", bus.cpu_en_o, bus.state_o); end
      end
    end
    bus.step_i = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      next_cyc(); #1;
      if (bus.cpu_en_o === 1'b1) begin
        found++;
        if (found == 1) lat = k;
      end
    end
    ret_model++;
    n_cmp++; if (found != 1) begin n_fail++; $display("FAIL step_pulses: got %0d want 1", found); end
    n_cmp++; if (lat != 8) begin n_fail++; $display("FAIL step_latency: got %0d want 8", lat); end
    n_cmp++; if (bus.state_o !== 2'b00) begin n_fail++; $display("FAIL step_state: got %b want 00", bus.state_o); end
    n_cmp++; if (bus.retired_o !== ret_model) begin n_fail++; $display("FAIL step_retired: got %0d want %0d", bus.retired_o, ret_model); end
    bus.step_i = 1'b0;
    repeat (12) next_cyc();
  endtask

  task automatic test_breakpoint();
    bit exp_en;
    int guard;
    bus.bp_en_i = 1'b1; bus.bp_addr_i = 6'd5; bus.pc_i = 6'($urandom_range(6, 63));
    bus.slow_i = 1'b0; bus.run_i = 1'b1;
    next_cyc();
    repeat ($urandom_range(4, 12)) begin
      #1;
      exp_en = model_tick(cyc, 1'b0);
      n_cmp++; if (bus.cpu_en_o !== exp_en) begin n_fail++; $display("FAIL bp_pre_en: got %b want %b", bus.cpu_en_o, exp_en); end
      if (exp_en) ret_model++;
      next_cyc();
    end
    bus.pc_i = 6'd5;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    guard = 0;
    #1;
    while (!model_tick(cyc, 1'b0) && guard < 8) begin
      n_cmp++; if (bus.cpu_en_o !== 1'b0) begin n_fail++; $display("FAIL bp_wait_en: got %b want 0", bus.cpu_en_o); end
      next_cyc(); #1; guard++;
    end
    n_cmp++; if (bus.cpu_en_o !== 1'b0) begin n_fail++; $display("FAIL bp_hit_en: got %b want 0", bus.cpu_en_o); end
    next_cyc(); #1;
    n_cmp++; if (bus.state_o !== 2'b11) begin n_fail++; $display("FAIL bp_state: got %b want 11", bus.state_o); end
    n_cmp++; if (bus.halted_o !== 1'b1) begin n_fail++; $display("FAIL bp_halted: got %b want 1", bus.halted_o); end
    repeat (10) begin
      bus.pc_i = 6'($urandom_range(0, 63));
      next_cyc(); #1;
      n_cmp++; if (bus.state_o !== 2'b11 || bus.cpu_en_o !== 1'b0) begin n_fail++; $display("FAIL halt_hold: state=%b en=%b want 11/0", bus.state_o, bus.cpu_en_o); end
    end
    bus.pc_i = 6'd5; bus.run_i = 1'b0;
    press_step("bp");
    n_cmp++; if (bus.halted_o !== 1'b0) begin n_fail++; $display("FAIL bp_unhalt: got %b want 0", bus.halted_o); end
`else
    repeat (32) begin
      #1;
      exp_en = model_tick(cyc, 1'b0);
      n_cmp++; if (bus.cpu_en_o !== exp_en) begin n_fail++; $display("FAIL nobp_en: got %b want %b", bus.cpu_en_o, exp_en); end
      n_cmp++; if (bus.state_o !== 2'b01 || bus.halted_o !== 1'b0) begin n_fail++; $display("FAIL nobp_state: state=%b halted=%b want 01/0", bus.state_o, bus.halted_o); end
      if (exp_en) ret_model++;
      next_cyc();
    end
    guard = 0;
    bus.run_i = 1'b0;
    #1;
    exp_en = model_tick(cyc, 1'b0);
    if (exp_en) ret_model++;
    next_cyc(); #1;
    n_cmp++; if (bus.retired_o !== ret_model) begin n_fail++; $display("FAIL nobp_retired: got %0d want %0d (guard %0d)", bus.retired_o, ret_model, guard); end
`endif
    bus.bp_en_i = 1'b0;
  endtask

  task automatic test_reset_mid_step();
    int guard;
    guard = 0;
    bus.step_i = 1'b1;
    next_cyc(); #1;
    while (bus.cpu_en_o !== 1'b1 && guard < 20) begin
      next_cyc(); #1; guard++;
    end
    n_cmp++; if (bus.state_o !== 2'b10) begin n_fail++; $display("FAIL mid_step_state: got %b want 10", bus.state_o); end
    rstn = 1'b0; bus.step_i = 1'b0;
    #1;
    n_cmp++; if (bus.cpu_en_o !== 1'b0) begin n_fail++; $display("FAIL rst_step_en: got %b want 0", bus.cpu_en_o); end
    n_cmp++; if (bus.state_o !== 2'b00) begin n_fail++; $display("FAIL rst_step_state: got %b want 00", bus.state_o); end
    n_cmp++; if (bus.retired_o !== 32'd0) begin n_fail++; $display("FAIL rst_step_retired: got %0d want 0", bus.retired_o); end
    next_cyc();
    rstn = 1'b1; ret_model = 32'd0;
    repeat (12) begin
      next_cyc(); #1;
      n_cmp++; if (bus.state_o !== 2'b00 || bus.cpu_en_o !== 1'b0) begin n_fail++; $display("FAIL post_rst: state=%b en=%b want 00/0", bus.state_o, bus.cpu_en_o); end
    end
  endtask

  task automatic test_saturate_clear();
    bit exp_en;
    int guard;
    force dut.retired_r = 32'hFFFF_FFFD;
    next_cyc();
    release dut.retired_r;
    ret_model = 32'hFFFF_FFFD;
    #1;
    n_cmp++; if (bus.retired_o !== ret_model) begin n_fail++; $display("FAIL preset: got %h want %h", bus.retired_o, ret_model); end
    bus.slow_i = 1'b0; bus.run_i = 1'b1;
    next_cyc();
    repeat (24) begin
      #1;
      exp_en = model_tick(cyc, 1'b0);
      n_cmp++; if (bus.cpu_en_o !== exp_en) begin n_fail++; $display("FAIL sat_en: got %b want %b", bus.cpu_en_o, exp_en); end
      if (exp_en && ret_model != 32'hFFFF_FFFF) ret_model++;
      next_cyc(); #1;
      n_cmp++; if (bus.retired_o !== ret_model) begin n_fail++; $display("FAIL sat_retired: got %h want %h", bus.retired_o, ret_model); end
    end
    n_cmp++; if (bus.retired_o !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_final: got %h want ffffffff", bus.retired_o); end
    guard = 0;
    while (!model_tick(cyc, 1'b0) && guard < 8) begin next_cyc(); #1; guard++; end
    bus.clr_i = 1'b1;
    #1;
    n_cmp++; if (bus.cpu_en_o !== 1'b0) begin n_fail++; $display("FAIL clr_en: got %b want 0", bus.cpu_en_o); end
    next_cyc();
    bus.clr_i = 1'b0; bus.run_i = 1'b0;
    #1;
    ret_model = 32'd0;
    n_cmp++; if (bus.state_o !== 2'b00) begin n_fail++; $display("FAIL clr_state: got %b want 00", bus.state_o); end
    n_cmp++; if (bus.retired_o !== 32'd0) begin n_fail++; $display("FAIL clr_retired: got %h want 0", bus.retired_o); end
    next_cyc(); #1;
    n_cmp++; if (bus.state_o !== 2'b00 || bus.retired_o !== ret_model) begin n_fail++; $display("FAIL clr_hold: state=%b ret=%h want 00/0", bus.state_o, bus.retired_o); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_step();
    test_breakpoint();
    test_reset_mid_step();
    test_saturate_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
